dispensador_troco: RTL and testbench
====================================

// Module: dispensador_troco
// PURPOSE
//  Downstream of the coin comparator. It consumes the product-release (LP) and refund (DM) decisions.
//  It latches the accumulated coin value and the product price, then drives the product-gate pulse.
//  Change or refund is paid out greedily, one physical coin at a time, with sensor confirmation.
//  It tracks per-denomination coin stock, and reports busy, done, error and no-change conditions to the main FSM.
// PARAMETERS
//  VAL1        1           value of coin code 2'b01
//  VAL2        2           value of coin code 2'b10
//  VAL3        5           value of coin code 2'b11 (VAL3>VAL2>VAL1>0, all <=15)
//  STOCK_INIT  4           initial stock per denomination after reset (<=15)
//  PULSE       5_000_000   cycles a gate/eject command is held (100 ms @50 MHz)
//  TIMEOUT     25_000_000  max cycles from eject start to sensor_moeda (>PULSE)
// PORTS
//  clk            in   1  system clock
//  reset          in   1  synchronous, active-high
//  liberar        in   1  LP level from comparator; rising edge = sale
//  devolver       in   1  DM level from comparator; rising edge = full refund
//  valor_moedas   in   4  accumulated coin value, sampled on the accepted edge
//  valor_produto  in   3  product price, sampled on the accepted edge
//  sensor_moeda   in   1  chute sensor, 1-cycle-or-longer high per coin passed
//  produto_out    out  1  product gate drive
//  ejetar         out  2  coin code being ejected; 2'b00 = none
//  troco_rest     out  4  change still owed
//  ocupado        out  1  high in every state except IDLE and ERRO
//  fim            out  1  one-cycle pulse when a transaction completes (ok or sem_troco)
//  sem_troco      out  1  sticky until next accepted edge: exact change impossible
//  erro           out  1  sticky until reset: sensor timeout
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; edge registers 0; all three stock counters = STOCK_INIT.
//  Edge detect: one register per input. edge = in & ~in_q. Edges are accepted only in IDLE.
//    While not in IDLE, edges are ignored. A level held high across return to IDLE does not retrigger.
//  States and transitions:
//  IDLE: on devolver edge (has priority if both edges fire in the same cycle):
//      troco_rest<=valor_moedas, modo=REFUND, clear sem_troco, go SELECT.
//    On liberar edge with valor_moedas>=valor_produto:
//      troco_rest<=valor_moedas-valor_produto, modo=SALE, clear sem_troco, go GATE.
//    On liberar edge with valor_moedas<valor_produto: treated as refund.
//  GATE: produto_out=1 for exactly PULSE cycles, then go SELECT.
//  SELECT (1 cycle):
//    troco_rest==0 -> DONE.
//    Otherwise pick the largest code whose stock>0 and whose value<=troco_rest.
//      Load the timer, decrement that stock, go EJECT.
//    If no such code exists -> sem_troco<=1, go DONE.
//  EJECT: ejetar=code for PULSE cycles.
//    The timeout counter runs from the first EJECT cycle.
//    A sensor high here is latched as ack. Go WAIT.
//  WAIT: ejetar=00.
//    On ack or sensor_moeda -> troco_rest -= value(code), go SELECT.
//    When the timeout counter reaches TIMEOUT with no ack -> erro<=1, go ERRO.
//  DONE: fim=1 for one cycle, go IDLE.
//  ERRO: all drives 0, ocupado=0, ignore inputs; exit only by reset.
//  Arithmetic: 4-bit unsigned. Subtraction is guarded by the <= check, so no wrap.
//    Stock never decrements below 0.
//  Extra sensor pulses outside EJECT/WAIT are ignored. One ack is credited per eject.
//  Reset mid-operation: immediate IDLE, drives 0, stock reloaded, no fim pulse.
//  Latency: edge to first produto_out = 1 cycle. Edge to first ejetar on refund = 2 cycles.
// STRUCTURE
//  Shared package maquina_pkg:
//    coin codes (MOEDA_NENHUMA=2'b00, M1, M2, M3);
//    state encoding localparams;
//    value-of-code function.
//  Sub-module temporizador_pulso: loadable down-counter with done flag (parameter WIDTH).
//    Two instances: pulse length and timeout.
//  Top level holds the FSM, edge detectors, stock counters and greedy selector (combinational).
// TESTING (PULSE=2, TIMEOUT=8, defaults otherwise; sensor echoes 1 cycle after eject ends)
//  liberar edge, moedas=9, produto=4 -> produto_out 2 cycles; ejetar=11 once; troco_rest 5->0;
//    fim pulse; stock3=3.
//  devolver edge, moedas=7 -> ejetar 11 then 10, nothing else; produto_out never high;
//    fim; stock3=3, stock2=3.
//  stock3 drained to 0, then sale with troco 5 -> ejetar 10,10,01; fim; sem_troco=0.
//  all stocks 0, devolver moedas=3 -> no ejetar; sem_troco=1; fim;
//    next accepted edge clears sem_troco.
//  sensor held 0 -> erro=1 exactly 8 cycles after eject start; ejetar=00, ocupado=0;
//    edges ignored until reset.
//  liberar+devolver same cycle -> refund path; reset during EJECT -> outputs 0 next cycle,
//    stocks=4, no fim.

Source files
------------

// File: rtl/maquina_pkg.sv
// Shared definitions for the change dispenser: coin codes, FSM states and coin values.
package maquina_pkg;

  localparam logic [1:0] MOEDA_NENHUMA = 2'b00;
  localparam logic [1:0] M1            = 2'b01;
  localparam logic [1:0] M2            = 2'b10;
  localparam logic [1:0] M3            = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GATE   = 3'd1,
    SELECT = 3'd2,
    EJECT  = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5,
    ERRO   = 3'd6
  } estado_t;

  function automatic logic [3:0] valor_moeda(input logic [1:0] code,
                                             input logic [3:0] v1,
                                             input logic [3:0] v2,
                                             input logic [3:0] v3);
    case (code)
      M1:      return v1;
      M2:      return v2;
      M3:      return v3;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/temporizador_pulso.sv
// Loadable down-counter; ultimo_c flags the final cycle of a loaded interval.
module temporizador_pulso #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             carregar,
  input  logic [WIDTH-1:0] valor,
  output logic             ultimo_c
);

  logic [WIDTH-1:0] contagem;

  always_ff @(posedge clk) begin
    if (reset)
      contagem <= '0;
    else if (carregar)
      contagem <= valor;
    else if (contagem != '0)
      contagem <= contagem - WIDTH'(1);
  end

  assign ultimo_c = (contagem == WIDTH'(1));

endmodule

// File: rtl/dispensador_troco.sv
// Change dispenser: product gate pulse, greedy coin payout with sensor confirmation,
// per-denomination stock tracking and status reporting.
module dispensador_troco
  import maquina_pkg::*;
#(
  parameter int unsigned VAL1       = 1,
  parameter int unsigned VAL2       = 2,
  parameter int unsigned VAL3       = 5,
  parameter int unsigned STOCK_INIT = 4,
  parameter int unsigned PULSE      = 5_000_000,
  parameter int unsigned TIMEOUT    = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       liberar,
  input  logic       devolver,
  input  logic [3:0] valor_moedas,
  input  logic [2:0] valor_produto,
  input  logic       sensor_moeda,
  output logic       produto_out,
  output logic [1:0] ejetar,
  output logic [3:0] troco_rest,
  output logic       ocupado,
  output logic       fim,
  output logic       sem_troco,
  output logic       erro
);

  localparam int unsigned PW = $clog2(PULSE + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] V1 = 4'(VAL1);
  localparam logic [3:0] V2 = 4'(VAL2);
  localparam logic [3:0] V3 = 4'(VAL3);
  localparam logic [3:0] S0 = 4'(STOCK_INIT);

  estado_t    estado;
  logic       liberar_q, devolver_q, ack;
  logic [1:0] codigo;
  logic [3:0] stock1, stock2, stock3;

  logic       edge_lib_c, edge_dev_c, aceita_venda_c, carrega_ejecao_c, carrega_pulso_c;
  logic       pulso_fim_c, tmo_fim_c;
  logic [1:0] sel_c;

  assign edge_lib_c       = liberar & ~liberar_q;
  assign edge_dev_c       = devolver & ~devolver_q;
  assign aceita_venda_c   = (estado == IDLE) && edge_lib_c && !edge_dev_c &&
                            (valor_moedas >= {1'b0, valor_produto});
  assign carrega_ejecao_c = (estado == SELECT) && (troco_rest != 4'd0) && (sel_c != MOEDA_NENHUMA);
  assign carrega_pulso_c  = aceita_venda_c | carrega_ejecao_c;

  // Greedy pick: largest denomination in stock that still fits the amount owed.
  always_comb begin
    sel_c = MOEDA_NENHUMA;
    if (stock3 != 4'd0 && V3 <= troco_rest)
      sel_c = M3;
    else if (stock2 != 4'd0 && V2 <= troco_rest)
      sel_c = M2;
    else if (stock1 != 4'd0 && V1 <= troco_rest)
      sel_c = M1;
  end

  temporizador_pulso #(.WIDTH(PW)) u_pulso (
    .clk      (clk),
    .reset    (reset),
    .carregar (carrega_pulso_c),
    .valor    (PW'(PULSE)),
    .ultimo_c (pulso_fim_c)
  );

  temporizador_pulso #(.WIDTH(TW)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .carregar (carrega_ejecao_c),
    .valor    (TW'(TIMEOUT)),
    .ultimo_c (tmo_fim_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      estado      <= IDLE;
      liberar_q   <= 1'b0;
      devolver_q  <= 1'b0;
      ack         <= 1'b0;
      codigo      <= MOEDA_NENHUMA;
      stock1      <= S0;
      stock2      <= S0;
      stock3      <= S0;
      produto_out <= 1'b0;
      ejetar      <= MOEDA_NENHUMA;
      troco_rest  <= 4'd0;
      ocupado     <= 1'b0;
      fim         <= 1'b0;
      sem_troco   <= 1'b0;
      erro        <= 1'b0;
    end else begin
      liberar_q  <= liberar;
      devolver_q <= devolver;
      fim        <= 1'b0;
      case (estado)
        IDLE: begin
          // A liberar edge without enough credit falls through to a refund.
          if (edge_dev_c || (edge_lib_c && !aceita_venda_c)) begin
            troco_rest <= valor_moedas;
            sem_troco  <= 1'b0;
            ocupado    <= 1'b1;
            estado     <= SELECT;
          end else if (aceita_venda_c) begin
            troco_rest  <= valor_moedas - {1'b0, valor_produto};
            sem_troco   <= 1'b0;
            ocupado     <= 1'b1;
            produto_out <= 1'b1;
            estado      <= GATE;
          end
        end
        GATE: begin
          if (pulso_fim_c) begin
            produto_out <= 1'b0;
            estado      <= SELECT;
          end
        end
        SELECT: begin
          ack <= 1'b0;
          if (troco_rest == 4'd0) begin
            fim    <= 1'b1;
            estado <= DONE;
          end else if (sel_c != MOEDA_NENHUMA) begin
            codigo <= sel_c;
            ejetar <= sel_c;
            case (sel_c)
              M1:      stock1 <= stock1 - 4'd1;
              M2:      stock2 <= stock2 - 4'd1;
              default: stock3 <= stock3 - 4'd1;
            endcase
            estado <= EJECT;
          end else begin
            sem_troco <= 1'b1;
            fim       <= 1'b1;
            estado    <= DONE;
          end
        end
        EJECT: begin
          if (sensor_moeda)
            ack <= 1'b1;
          if (pulso_fim_c) begin
            ejetar <= MOEDA_NENHUMA;
            estado <= WAIT;
          end
        end
        WAIT: begin
          if (ack || sensor_moeda) begin
            troco_rest <= troco_rest - valor_moeda(codigo, V1, V2, V3);
            estado     <= SELECT;
          end else if (tmo_fim_c) begin
            erro    <= 1'b1;
            ocupado <= 1'b0;
            estado  <= ERRO;
          end
        end
        DONE: begin
          ocupado <= 1'b0;
          estado  <= IDLE;
        end
        ERRO: begin
          estado <= ERRO;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dispensador_troco.sv
// Directed self-checking bench for dispensador_troco with short pulse/timeout lengths.
module tb_dispensador_troco;

  logic       clk = 1'b0;
  logic       reset, liberar, devolver, sensor_moeda;
  logic [3:0] valor_moedas;
  logic [2:0] valor_produto;
  logic       produto_out, ocupado, fim, sem_troco, erro;
  logic [1:0] ejetar;
  logic [3:0] troco_rest;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] ej_log[$];
  logic [1:0] ej_prev = 2'b00;
  int         prod_cnt = 0;
  int         fim_cnt = 0;
  bit         sensor_en = 1'b1;

  int fb, pb, eb;

  dispensador_troco #(
    .VAL1(1), .VAL2(2), .VAL3(5), .STOCK_INIT(4), .PULSE(2), .TIMEOUT(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .liberar       (liberar),
    .devolver      (devolver),
    .valor_moedas  (valor_moedas),
    .valor_produto (valor_produto),
    .sensor_moeda  (sensor_moeda),
    .produto_out   (produto_out),
    .ejetar        (ejetar),
    .troco_rest    (troco_rest),
    .ocupado       (ocupado),
    .fim           (fim),
    .sem_troco     (sem_troco),
    .erro          (erro)
  );

  always #5 clk = ~clk;

  // Record each ejected coin, gate cycles and fim pulses.
  always @(negedge clk) begin
    if (ejetar != 2'b00 && ej_prev == 2'b00)
      ej_log.push_back(ejetar);
    ej_prev <= ejetar;
    if (produto_out) prod_cnt <= prod_cnt + 1;
    if (fim)         fim_cnt  <= fim_cnt + 1;
  end

  // Coin chute model: one-cycle sensor pulse right after each eject command drops.
  initial begin
    logic [1:0] prev;
    prev = 2'b00;
    sensor_moeda = 1'b0;
    forever begin
      @(negedge clk);
      sensor_moeda = sensor_en && (prev != 2'b00) && (ejetar == 2'b00);
      prev = ejetar;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_fim(input int base, input string tag);
    int k;
    k = 0;
    while (fim_cnt == base && k < 80) begin
      tick(1);
      k++;
    end
    check({tag, "_fim_seen"}, 32'(fim_cnt != base), 1);
    tick(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    liberar = 1'b0;
    devolver = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic run_txn(input logic lib, input logic dev, input logic [3:0] m,
                         input logic [2:0] p, input string tag);
    int base;
    base = fim_cnt;
    valor_moedas = m;
    valor_produto = p;
    liberar = lib;
    devolver = dev;
    tick(1);
    wait_fim(base, tag);
    liberar = 1'b0;
    devolver = 1'b0;
    tick(1);
  endtask

  function automatic logic [31:0] seq_since(input int base);
    logic [31:0] s;
    s = 32'd0;
    for (int i = base; i < ej_log.size(); i++)
      s = (s << 2) | 32'(ej_log[i]);
    return s;
  endfunction

  function automatic logic [31:0] stocks();
    return 32'({dut.stock3, dut.stock2, dut.stock1});
  endfunction

  initial begin
    reset = 1'b1;
    liberar = 1'b0;
    devolver = 1'b0;
    valor_moedas = 4'd0;
    valor_produto = 3'd0;
    tick(2);
    check("reset_outputs", 32'({produto_out, ejetar, troco_rest, ocupado, fim, sem_troco, erro}), 0);
    check("reset_stocks", stocks(), 32'h444);
    reset = 1'b0;
    tick(1);

    // Sale 9 - 4: gate 2 cycles, one 5-coin, stock3 -> 3.
    fb = fim_cnt; pb = prod_cnt; eb = ej_log.size();
    valor_moedas = 4'd9; valor_produto = 3'd4; liberar = 1'b1;
    tick(1);
    check("t1_gate_latency", 32'(produto_out), 1);
    check("t1_troco_init", 32'(troco_rest), 5);
    wait_fim(fb, "t1");
    liberar = 1'b0;
    check("t1_gate_cycles", 32'(prod_cnt - pb), 2);
    check("t1_coin_count", 32'(ej_log.size() - eb), 1);
    check("t1_coin_seq", seq_since(eb), 32'h3);
    check("t1_troco_end", 32'(troco_rest), 0);
    check("t1_fim_once", 32'(fim_cnt - fb), 1);
    check("t1_stocks", stocks(), 32'h344);
    check("t1_sem_troco", 32'(sem_troco), 0);

    // Refund 7: coins 11 then 10, gate never opens.
    do_reset();
    fb = fim_cnt; pb = prod_cnt; eb = ej_log.size();
    valor_moedas = 4'd7; devolver = 1'b1;
    tick(1);
    check("t2_select_cycle", 32'({produto_out, ejetar, ocupado}), 32'b0001);
    tick(1);
    check("t2_eject_latency", 32'(ejetar), 3);
    wait_fim(fb, "t2");
    devolver = 1'b0;
    check("t2_coin_count", 32'(ej_log.size() - eb), 2);
    check("t2_coin_seq", seq_since(eb), 32'b1110);
    check("t2_no_gate", 32'(prod_cnt - pb), 0);
    check("t2_fim_once", 32'(fim_cnt - fb), 1);
    check("t2_stocks", stocks(), 32'h334);

    // Drain 5-coins, then sale with change 5 must pay 2,2,1.
    do_reset();
    for (int i = 0; i < 4; i++) run_txn(1'b0, 1'b1, 4'd5, 3'd0, "t3_drain");
    check("t3_stock3_empty", 32'(dut.stock3), 0);
    fb = fim_cnt; eb = ej_log.size();
    run_txn(1'b1, 1'b0, 4'd9, 3'd4, "t3_sale");
    check("t3_coin_count", 32'(ej_log.size() - eb), 3);
    check("t3_coin_seq", seq_since(eb), 32'b101001);
    check("t3_sem_troco", 32'(sem_troco), 0);
    check("t3_fim_once", 32'(fim_cnt - fb), 1);
    check("t3_stocks", stocks(), 32'h023);

    // Empty every stock, then a refund that cannot be paid.
    do_reset();
    run_txn(1'b0, 1'b1, 4'd15, 3'd0, "t4_r1");
    check("t4_stocks_a", stocks(), 32'h144);
    eb = ej_log.size();
    run_txn(1'b0, 1'b1, 4'd15, 3'd0, "t4_r2");
    check("t4_seq_mixed", seq_since(eb), 32'b11101010100101);
    run_txn(1'b0, 1'b1, 4'd2, 3'd0, "t4_r3");
    check("t4_stocks_empty", stocks(), 32'h000);
    fb = fim_cnt; eb = ej_log.size();
    run_txn(1'b0, 1'b1, 4'd3, 3'd0, "t4_nochange");
    check("t4_no_coins", 32'(ej_log.size() - eb), 0);
    check("t4_sem_troco_set", 32'(sem_troco), 1);
    check("t4_fim_once", 32'(fim_cnt - fb), 1);
    tick(3);
    check("t4_sem_troco_sticky", 32'(sem_troco), 1);
    fb = fim_cnt; pb = prod_cnt;
    valor_moedas = 4'd4; valor_produto = 3'd4; liberar = 1'b1;
    tick(1);
    check("t4_sem_troco_clear", 32'(sem_troco), 0);
    wait_fim(fb, "t4_exact");
    liberar = 1'b0;
    check("t4_exact_gate", 32'(prod_cnt - pb), 2);
    check("t4_exact_sem_troco", 32'(sem_troco), 0);

    // Sensor silent: erro exactly 8 cycles after eject start, then locked.
    do_reset();
    sensor_en = 1'b0;
    valor_moedas = 4'd1; devolver = 1'b1;
    tick(2);
    check("t5_eject_start", 32'(ejetar), 1);
    tick(7);
    check("t5_before_timeout", 32'({erro, ocupado}), 32'b01);
    tick(1);
    check("t5_timeout", 32'({erro, ejetar, ocupado}), 32'b1000);
    devolver = 1'b0;
    tick(1);
    valor_moedas = 4'd9; valor_produto = 3'd4; liberar = 1'b1; devolver = 1'b1;
    tick(3);
    check("t5_locked", 32'({produto_out, ejetar, ocupado, erro}), 32'b00001);
    liberar = 1'b0; devolver = 1'b0; sensor_en = 1'b1;
    do_reset();
    check("t5_reset_clears", 32'(erro), 0);

    // Both edges together take the refund path; reset during EJECT aborts cleanly.
    fb = fim_cnt;
    valor_moedas = 4'd9; valor_produto = 3'd4; liberar = 1'b1; devolver = 1'b1;
    tick(1);
    check("t6_refund_path", 32'({produto_out, troco_rest}), 32'h09);
    tick(1);
    check("t6_eject", 32'(ejetar), 3);
    check("t6_stock_dec", 32'(dut.stock3), 3);
    reset = 1'b1; liberar = 1'b0; devolver = 1'b0;
    tick(1);
    check("t6_reset_outputs", 32'({produto_out, ejetar, troco_rest, ocupado, fim}), 0);
    check("t6_reset_stocks", stocks(), 32'h444);
    reset = 1'b0;
    tick(5);
    check("t6_no_fim", 32'(fim_cnt - fb), 0);
    check("t6_idle", 32'(ocupado), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
